// File: rtl/interconn_pkg.sv
// ---------------------------------------------------------------------------
// interconn_pkg
// Shared constants and types for the interconnect receive buffer.
//   N_DEF      default number of MVUs (width of the source one-hot)
//   W_DEF      default data word width
//   BADDR_DEF  default data-memory address width
//   rbuf_entry_t  one buffered delivery {addr, word, from} at default widths
//   entry_width() packed width of an entry for arbitrary N/W/BADDR
// ---------------------------------------------------------------------------
package interconn_pkg;

    localparam int N_DEF     = 8;
    localparam int W_DEF     = 64;
    localparam int BADDR_DEF = 15;

    // Field order matches the packed layout used inside the buffer:
    // addr in the MSBs, source one-hot in the LSBs.
    typedef struct packed {
        logic [BADDR_DEF-1:0] addr;
        logic [W_DEF-1:0]     word;
        logic [N_DEF-1:0]     from;
    } rbuf_entry_t;

    function automatic int entry_width(input int n, input int w, input int baddr);
        return n + w + baddr;
    endfunction

endpackage

// File: rtl/interconn_rbuf_mem.sv
// ---------------------------------------------------------------------------
// interconn_rbuf_mem
// Storage array for the receive buffer: DEPTH entries of EW bits, one
// synchronous write port and one asynchronous read port. No reset; the
// owning FIFO tracks which entries are valid.
//   clk    clock
//   we     write enable (write on rising edge)
//   waddr  write index
//   wdata  write entry
//   raddr  read index
//   rdata  read entry (combinational from raddr)
// ---------------------------------------------------------------------------
module interconn_rbuf_mem #(
    parameter int DEPTH = 8,
    parameter int EW    = 87
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [EW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [EW-1:0]            rdata
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read: when the FIFO is full and pushes and pops in the
    // same cycle, waddr == raddr and the pop must see the old entry.
    assign rdata = mem[raddr];

endmodule

// File: rtl/interconn_recv_buf.sv
// ---------------------------------------------------------------------------
// interconn_recv_buf
// Receive buffer between the interconnect and an MVU data memory. Words
// delivered by the interconnect are queued and written to memory whenever
// the MVU is not using its memory port itself. Words arriving while the
// buffer is full (and not draining) are dropped and counted.
//
// Handshake: recv_en is a one-way strobe with no ready; a word presented
// with recv_en=1 is either accepted that edge or dropped (overflow set).
// mem_we is a one-cycle write strobe qualifying mem_addr/mem_wdata/mem_from;
// the memory always accepts it.
//
// Ports
//   clk, clr                 clock, synchronous active-high reset
//   recv_en/from/addr/word   delivered word and its source / destination
//   mem_busy                 MVU-internal write owns the memory port
//   ovf_clr                  clear overflow flag and drop counter
//   mem_we/addr/wdata/from   registered write to the MVU data memory
//   count, full, empty       occupancy and its derived flags
//   overflow, drop_cnt       sticky drop flag, saturating drop counter
// ---------------------------------------------------------------------------
module interconn_recv_buf
    import interconn_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int BADDR = BADDR_DEF,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     recv_en,
    input  logic [N-1:0]             recv_from,
    input  logic [BADDR-1:0]         recv_addr,
    input  logic [W-1:0]             recv_word,
    input  logic                     mem_busy,
    input  logic                     ovf_clr,
    output logic                     mem_we,
    output logic [BADDR-1:0]         mem_addr,
    output logic [W-1:0]             mem_wdata,
    output logic [N-1:0]             mem_from,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = entry_width(N, W, BADDR);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    // The MVU's own writes win the memory port; a full buffer can still
    // take a word in a cycle where it also pops one.
    assign pop  = (count != '0) & ~mem_busy;
    assign push = recv_en & ((count < DEPTH_C) | pop);
    assign drop = recv_en & ~push;

    assign wr_entry = {recv_addr, recv_word, recv_from};

    interconn_rbuf_mem #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_from  <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is plain overflow.
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            mem_we <= pop;
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                mem_addr  <= rd_entry[EW-1 -: BADDR];
                mem_wdata <= rd_entry[N +: W];
                mem_from  <= rd_entry[N-1:0];
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A drop in the same cycle as ovf_clr restarts the count at 1.
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_clr) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (ovf_clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: tb/tb_interconn_recv_buf.sv
// ---------------------------------------------------------------------------
// tb_interconn_recv_buf
// Self-checking bench: directed scenarios followed by a long random run,
// all compared against a queue-based reference model each cycle.
// ---------------------------------------------------------------------------
module tb_interconn_recv_buf;
    import interconn_pkg::*;

    localparam int N     = N_DEF;
    localparam int W     = W_DEF;
    localparam int BADDR = BADDR_DEF;
    localparam int DEPTH = 8;
    localparam int EW    = BADDR + W + N;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   clr = 1'b1;
    logic                   recv_en = 1'b0;
    logic [N-1:0]           recv_from = '0;
    logic [BADDR-1:0]       recv_addr = '0;
    logic [W-1:0]           recv_word = '0;
    logic                   mem_busy = 1'b0;
    logic                   ovf_clr = 1'b0;
    logic                   mem_we;
    logic [BADDR-1:0]       mem_addr;
    logic [W-1:0]           mem_wdata;
    logic [N-1:0]           mem_from;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   overflow;
    logic [7:0]             drop_cnt;

    interconn_recv_buf #(
        .N(N), .W(W), .BADDR(BADDR), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .recv_en   (recv_en),
        .recv_from (recv_from),
        .recv_addr (recv_addr),
        .recv_word (recv_word),
        .mem_busy  (mem_busy),
        .ovf_clr   (ovf_clr),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_from  (mem_from),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];     // words accepted, not yet written out
    logic          exp_we;
    rbuf_entry_t   exp_out;      // last word written to memory
    logic          exp_ovf;
    int            exp_drops;    // true number of drops since last clear

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_we    = 1'b0;
        exp_out   = '0;
        exp_ovf   = 1'b0;
        exp_drops = 0;
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of inputs (called at negedge), advances the model
    // with the same inputs, then checks every output at the next negedge.
    task automatic step(input logic en, input logic [BADDR-1:0] a, input logic [W-1:0] d,
                        input logic [N-1:0] f, input logic busy, input logic oc,
                        input logic rst);
        bit m_pop;
        bit m_accept;
        int sat;
        recv_en   = en;
        recv_addr = a;
        recv_word = d;
        recv_from = f;
        mem_busy  = busy;
        ovf_clr   = oc;
        clr       = rst;

        if (rst) begin
            model_reset();
        end else begin
            m_pop    = (exp_q.size() > 0) && !busy;
            m_accept = en && ((exp_q.size() < DEPTH) || m_pop);
            exp_we   = m_pop;
            if (m_pop) begin
                exp_out = rbuf_entry_t'(exp_q.pop_front());
            end
            if (m_accept) begin
                exp_q.push_back({a, d, f});
            end
            if (en && !m_accept) begin
                exp_ovf   = 1'b1;
                exp_drops = oc ? 1 : exp_drops + 1;
            end else if (oc) begin
                exp_ovf   = 1'b0;
                exp_drops = 0;
            end
        end

        @(posedge clk);
        @(negedge clk);

        sat = (exp_drops > 255) ? 255 : exp_drops;
        check("mem_we", 64'(mem_we), 64'(exp_we));
        if (exp_we) begin
            check("mem_addr",  64'(mem_addr),  64'(exp_out.addr));
            check("mem_wdata", 64'(mem_wdata), 64'(exp_out.word));
            check("mem_from",  64'(mem_from),  64'(exp_out.from));
        end
        check("count",    64'(count),    64'(exp_q.size()));
        check("full",     64'(full),     64'(exp_q.size() == DEPTH));
        check("empty",    64'(empty),    64'(exp_q.size() == 0));
        check("overflow", 64'(overflow), 64'(exp_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(sat));
    endtask

    function automatic logic [N-1:0] rand_from();
        logic [N-1:0] v;
        v = '0;
        v[$urandom_range(0, N - 1)] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    task automatic push_rand(input logic busy);
        step(1'b1, BADDR'($urandom()), rand_word(), rand_from(), busy, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic busy);
        step(1'b0, '0, '0, '0, busy, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(negedge clk);

        // Reset state.
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Single word, one-cycle drain.
        step(1'b1, 15'h0010, 64'hA5, 8'h04, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("single_addr",  64'(mem_addr),  64'h10);
        check("single_wdata", 64'(mem_wdata), 64'hA5);
        check("single_from",  64'(mem_from),  64'h04);
        idle(1'b0);

        // Stalled fill, one drop, then in-order drain.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, BADDR'(i), rand_word(), rand_from(), 1'b1, 1'b0, 1'b0);
        end
        check("stall_full", 64'(full), 64'h1);
        step(1'b1, 15'h7FFF, rand_word(), rand_from(), 1'b1, 1'b0, 1'b0);
        check("stall_drop", 64'(drop_cnt), 64'h1);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);

        // Full and streaming: simultaneous push/pop, pointers wrap.
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) push_rand(1'b1);
        for (int i = 0; i < 20; i++) push_rand(1'b0);
        check("stream_nodrop", 64'(drop_cnt), 64'h0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);

        // Drop counter saturation and clear priority.
        for (int i = 0; i < DEPTH; i++) push_rand(1'b1);
        for (int i = 0; i < 300; i++) push_rand(1'b1);
        check("sat_255", 64'(drop_cnt), 64'hFF);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        check("ovf_clr_alone", 64'(overflow), 64'h0);
        step(1'b1, 15'h1234, rand_word(), rand_from(), 1'b1, 1'b1, 1'b0);
        check("ovf_clr_drop", 64'(drop_cnt), 64'h1);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);

        // Reset mid-drain with five words queued.
        for (int i = 0; i < 6; i++) push_rand(1'b1);
        idle(1'b0);
        check("pre_clr_count", 64'(count), 64'h5);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 15'h0ABC, 64'h0123_4567_89AB_CDEF, 8'h80, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("post_clr_first", 64'(mem_addr), 64'h0ABC);
        idle(1'b0);

        // Random traffic; occasional ovf_clr and reset.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), BADDR'($urandom()), rand_word(), rand_from(),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 999) == 0));
            if (count > DEPTH) check("count_bound", 64'(count), 64'(DEPTH));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);
        check("final_empty", 64'(empty), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interconn_recv_buf.md
INTERCONN_RECV_BUF -- requirements
Module: interconn_recv_buf

Interface
REQ-001 SHALL have parameter N, default 8, number of MVUs (width of the source one-hot).
REQ-002 SHALL have parameter W, default 64, data word width.
REQ-003 SHALL have parameter BADDR, default 15, memory address width.
REQ-004 SHALL have parameter DEPTH, default 8, FIFO entries; power of 2, at least 2.
REQ-005 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port clr  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port recv_en  in  1  interconnect delivers one word this cycle.
REQ-008 SHALL have port recv_from  in  N  one-hot source MVU of the delivered word.
REQ-009 SHALL have port recv_addr  in  BADDR  destination memory address.
REQ-010 SHALL have port recv_word  in  W  delivered data.
REQ-011 SHALL have port mem_busy  in  1  MVU-internal write owns the memory port this cycle; it has priority.
REQ-012 SHALL have port ovf_clr  in  1  clears the sticky overflow flag and the drop counter.
REQ-013 SHALL have port mem_we  out  1  write strobe to the MVU data memory.
REQ-014 SHALL have port mem_addr  out  BADDR  write address.
REQ-015 SHALL have port mem_wdata  out  W  write data.
REQ-016 SHALL have port mem_from  out  N  source one-hot of the word being written.
REQ-017 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.
REQ-018 SHALL have port full, empty  out  1 each  count==DEPTH, count==0.
REQ-019 SHALL have port overflow  out  1  sticky: one or more words dropped.
REQ-020 SHALL have port drop_cnt  out  8  dropped-word counter; saturates at 255.

Function
REQ-021 pop SHALL be computed each cycle as (count!=0) & !mem_busy, using pre-edge state.
REQ-022 push SHALL be computed each cycle as recv_en & (count<DEPTH | pop), so a full FIFO accepts a word in the same cycle it pops one.
REQ-023 On push, {recv_addr, recv_word, recv_from} SHALL be written at wr_ptr and wr_ptr SHALL advance modulo DEPTH.
REQ-024 On pop, the entry at rd_ptr SHALL be registered onto mem_addr/mem_wdata/mem_from with mem_we=1 on the next edge, and rd_ptr SHALL advance modulo DEPTH.
REQ-025 When there is no pop, mem_we SHALL be 0 on the next cycle; mem_addr/mem_wdata/mem_from SHALL hold their last values.
REQ-026 count SHALL update by +1 (push only), -1 (pop only), or 0 (both or neither).
REQ-027 Latency SHALL be 1 cycle: a word pushed into an empty FIFO at edge t, with mem_busy low in cycle t, SHALL show mem_we=1 in cycle t+1.
REQ-028 Order SHALL be strict FIFO; a word is never duplicated and never reordered.
REQ-029 When recv_en=1 and push=0 (full and no pop), the word SHALL be dropped, overflow SHALL be set to 1, and drop_cnt SHALL increment, saturating at 255.
REQ-030 ovf_clr SHALL zero overflow and drop_cnt; a drop in the same cycle SHALL take priority, leaving overflow=1 and drop_cnt=1.
REQ-031 While mem_busy=1, the FIFO SHALL stall, keep accepting words while not full, and issue no mem_we.
REQ-032 full and empty SHALL be derived from the registered count (registered, not combinational from inputs).

Reset
REQ-033 clr=1 at an edge SHALL set pointers, count, mem_we, mem_addr, mem_wdata, mem_from, overflow and drop_cnt to 0, giving empty=1 and full=0.
REQ-034 clr SHALL override push, pop and ovf_clr in the same cycle; in-flight entries are discarded and the storage array need not be cleared.

Structure
REQ-035 Shared package interconn_pkg SHALL hold the default N/W/BADDR constants and the typedef for the entry struct {addr, word, from}.
REQ-036 The storage array SHALL be the single sub-module interconn_rbuf_mem (DEPTH x entry, 1 write port, 1 read port, no reset); pointers, count and flags SHALL stay in the top module.

Verification
REQ-037 Reset, then recv_en for 1 cycle with addr=0x0010, word=0xA5, from=8'h04, mem_busy=0 -> next cycle mem_we=1, mem_addr=0x0010, mem_wdata=0xA5, mem_from=8'h04; count returns to 0.
REQ-038 mem_busy=1, push 8 words (addr 0..7) -> full=1, count=8, no mem_we; then a 9th word -> overflow=1, drop_cnt=1; release mem_busy -> addresses 0..7 written in order over 8 consecutive cycles.
REQ-039 Full FIFO, mem_busy=0, recv_en held for 20 cycles -> no drops, count stays 8, pointers wrap at least twice, output sequence matches input.
REQ-040 Hold the full/stalled condition for 300 pushes -> drop_cnt saturates at 255; ovf_clr alone -> overflow=0, drop_cnt=0; ovf_clr together with a drop -> overflow=1, drop_cnt=1.
REQ-041 Assert clr mid-drain with count=5 -> next cycle count=0, empty=1, mem_we=0; the first push after reset is the first word written out.
REQ-042 Random recv_en and mem_busy at 50% each for 10k cycles -> scoreboard shows in-order, lossless delivery whenever no drop was flagged, and count never exceeds DEPTH.
